// File: rtl/ulbf_coeffs_pkg.sv
// Shared FSM encodings and elaboration helpers for the ping-pong coefficient streamer.
package ulbf_coeffs_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int MAX_READ_LATENCY = 8;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) res++;
        return res;
    endfunction

endpackage

// File: rtl/ulbf_coeffs_out_fifo.sv
// Show-ahead sync FIFO holding {tlast, tdata}; data visible the cycle after the write.
// Writes beyond capacity are dropped; the upstream credit logic keeps that from happening.
module ulbf_coeffs_out_fifo
    import ulbf_coeffs_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16,
    parameter int CW    = clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_rdy_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             rd_vld_o,
    output logic [CW-1:0]    count_o
);
    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    assign push = wr_vld_i && (count_q != CW'(DEPTH));
    assign pop  = rd_rdy_i && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= wr_dat_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_dat_o = mem[rd_ptr_q];
    assign rd_vld_o = (count_q != '0);
    assign count_o  = count_q;

endmodule

// File: rtl/ulbf_coeffs_pingpong_streamer.sv
// Double-banked coefficient RAM streamed as AXIS blocks; go-to-first-beat RAM_READ_LATENCY+2 cycles.
// Reads are credit-limited against the output FIFO, so tready backpressure never drops or tears a beat.
module ulbf_coeffs_pingpong_streamer
    import ulbf_coeffs_pkg::*;
#(
    parameter int TDATA_WIDTH      = 64,
    parameter int TKEEP_WIDTH      = TDATA_WIDTH / 8,
    parameter int RAM_DEPTH        = 2048,
    parameter int AW               = clog2(RAM_DEPTH),
    parameter int RAM_READ_LATENCY = 4,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                   m_axis_clk,
    input  logic                   m_axis_rst,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [TDATA_WIDTH-1:0] wr_data,
    input  logic                   go,
    input  logic                   stop,
    input  logic                   continuous,
    input  logic [11:0]            niter,
    input  logic [11:0]            block_size,
    input  logic [AW-1:0]          rollover_addr,
    input  logic                   swap_req,
    output logic                   active_bank,
    output logic                   busy,
    output logic                   done,
    output logic [AW-1:0]          addrb_wire,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast
);
    localparam int CW = clog2(FIFO_DEPTH) + 1;

    logic [1:0]    state_q, state_d;
    logic [11:0]   niter_q, niter_d;
    logic [11:0]   bs_q, bs_d;
    logic [11:0]   beat_q, beat_d;
    logic [11:0]   blk_q, blk_d;
    logic [AW-1:0] roll_q, roll_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          cont_q, cont_d;
    logic          bank_q, bank_d;
    logic          swap_pend_q, swap_pend_d;
    logic          stop_pend_q, stop_pend_d;

    logic          issue;
    logic          issue_last;
    logic          swap_now;
    logic          credit_ok;
    int            inflight;

    logic [TDATA_WIDTH-1:0]      mem [2*RAM_DEPTH];
    logic [TDATA_WIDTH-1:0]      pipe_dat_q [RAM_READ_LATENCY];
    logic [RAM_READ_LATENCY-1:0] pipe_vld_q;
    logic [RAM_READ_LATENCY-1:0] pipe_last_q;

    logic [CW-1:0]        fifo_count;
    logic [TDATA_WIDTH:0] fifo_rd_dat;
    logic                 fifo_vld;
    logic                 fifo_pop;

    // Everything in the read pipe is already committed to a FIFO slot.
    assign inflight  = $countones(pipe_vld_q);
    assign credit_ok = (inflight + int'(fifo_count)) < FIFO_DEPTH;
    assign fifo_pop  = fifo_vld && m_axis_tready;

    always_comb begin
        state_d     = state_q;
        niter_d     = niter_q;
        bs_d        = bs_q;
        beat_d      = beat_q;
        blk_d       = blk_q;
        roll_d      = roll_q;
        addr_d      = addr_q;
        cont_d      = cont_q;
        bank_d      = bank_q;
        swap_pend_d = swap_pend_q;
        stop_pend_d = stop_pend_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        swap_now    = swap_pend_q || swap_req;

        // Outside RUN no block is being read, so a swap cannot tear anything.
        if ((state_q != ST_RUN) && swap_now) begin
            bank_d      = ~bank_q;
            swap_pend_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    niter_d     = niter;
                    bs_d        = block_size;
                    roll_d      = rollover_addr;
                    cont_d      = continuous;
                    addr_d      = '0;
                    beat_d      = '0;
                    blk_d       = '0;
                    stop_pend_d = 1'b0;
                    if ((block_size == '0) || ((niter == '0) && !continuous)) state_d = ST_DONE;
                    else                                                      state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop)     stop_pend_d = 1'b1;
                if (swap_req) swap_pend_d = 1'b1;
                if (credit_ok) begin
                    issue      = 1'b1;
                    issue_last = (beat_q == bs_q - 12'd1);
                    addr_d     = (addr_q == roll_q) ? '0 : addr_q + AW'(1);
                    if (issue_last) begin
                        beat_d = '0;
                        if (swap_now) begin
                            bank_d      = ~bank_q;
                            swap_pend_d = 1'b0;
                        end
                        if (stop_pend_q || stop || (!cont_q && (blk_q == niter_q - 12'd1)))
                            state_d = ST_DRAIN;
                        else
                            blk_d = blk_q + 12'd1;
                    end else begin
                        beat_d = beat_q + 12'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if ((inflight == 0) &&
                    ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop)))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_clk) begin
        if (m_axis_rst) begin
            state_q     <= ST_IDLE;
            niter_q     <= '0;
            bs_q        <= '0;
            beat_q      <= '0;
            blk_q       <= '0;
            roll_q      <= '0;
            addr_q      <= '0;
            cont_q      <= 1'b0;
            bank_q      <= 1'b0;
            swap_pend_q <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            niter_q     <= niter_d;
            bs_q        <= bs_d;
            beat_q      <= beat_d;
            blk_q       <= blk_d;
            roll_q      <= roll_d;
            addr_q      <= addr_d;
            cont_q      <= cont_d;
            bank_q      <= bank_d;
            swap_pend_q <= swap_pend_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // Host writes use the pre-toggle bank, so a same-cycle swap never redirects them.
    always_ff @(posedge m_axis_clk) begin
        if (wr_en) mem[{~bank_q, wr_addr}] <= wr_data;
    end

    always_ff @(posedge m_axis_clk) begin
        pipe_dat_q[0] <= mem[{bank_q, addr_q}];
        for (int i = 1; i < RAM_READ_LATENCY; i++) pipe_dat_q[i] <= pipe_dat_q[i-1];
    end

    always_ff @(posedge m_axis_clk) begin
        if (m_axis_rst) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue_last;
            for (int i = 1; i < RAM_READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    ulbf_coeffs_out_fifo #(
        .WIDTH (TDATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_out_fifo (
        .clk_i    (m_axis_clk),
        .rst_i    (m_axis_rst),
        .wr_vld_i (pipe_vld_q[RAM_READ_LATENCY-1]),
        .wr_dat_i ({pipe_last_q[RAM_READ_LATENCY-1], pipe_dat_q[RAM_READ_LATENCY-1]}),
        .rd_rdy_i (m_axis_tready),
        .rd_dat_o (fifo_rd_dat),
        .rd_vld_o (fifo_vld),
        .count_o  (fifo_count)
    );

    assign m_axis_tvalid = fifo_vld;
    assign m_axis_tdata  = fifo_vld ? fifo_rd_dat[TDATA_WIDTH-1:0] : '0;
    assign m_axis_tlast  = fifo_vld && fifo_rd_dat[TDATA_WIDTH];
    assign m_axis_tkeep  = '1;
    assign active_bank   = bank_q;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign addrb_wire    = addr_q;

endmodule

// File: tb/tb_ulbf_coeffs_pingpong_streamer.sv
// Directed scoreboard bench for the ping-pong coefficient streamer.
module tb_ulbf_coeffs_pingpong_streamer;
    localparam int TW  = 64;
    localparam int KW  = 8;
    localparam int AW  = 11;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [TW-1:0] wr_data;
    logic          go, stop, continuous, swap_req;
    logic [11:0]   niter, block_size;
    logic [AW-1:0] rollover_addr;
    logic          active_bank, busy, done;
    logic [AW-1:0] addrb_wire;
    logic          tvalid, tready, tlast;
    logic [TW-1:0] tdata;
    logic [KW-1:0] tkeep;

    always #5 clk = ~clk;

    ulbf_coeffs_pingpong_streamer dut (
        .m_axis_clk    (clk),
        .m_axis_rst    (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .go            (go),
        .stop          (stop),
        .continuous    (continuous),
        .niter         (niter),
        .block_size    (block_size),
        .rollover_addr (rollover_addr),
        .swap_req      (swap_req),
        .active_bank   (active_bank),
        .busy          (busy),
        .done          (done),
        .addrb_wire    (addrb_wire),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast)
    );

    typedef struct packed {
        logic [TW-1:0] dat;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            popped   = 0;
    int            done_cnt = 0;
    logic          stalled  = 1'b0;
    logic [TW-1:0] held_dat;
    logic          held_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stalled) begin
                chk("tvalid_held_under_stall", 64'(tvalid), 64'd1);
                if (tvalid) begin
                    chk("tdata_stable", tdata, held_dat);
                    chk("tlast_stable", 64'(tlast), 64'(held_last));
                end
            end
            stalled = 1'b0;
            if (tvalid) begin
                if (tready) begin
                    chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("beat_data", tdata, e.dat);
                        chk("beat_tlast", 64'(tlast), 64'(e.last));
                        chk("tkeep_ones", 64'(tkeep), 64'hFF);
                        popped++;
                    end
                end else begin
                    stalled   = 1'b1;
                    held_dat  = tdata;
                    held_last = tlast;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input int a, input logic [TW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    task automatic start(input int bs, input int ni, input int roll, input logic c);
        block_size    = 12'(bs);
        niter         = 12'(ni);
        rollover_addr = AW'(roll);
        continuous    = c;
        go            = 1'b1;
        tick();
        go            = 1'b0;
    endtask

    task automatic push(input logic [TW-1:0] d, input logic l);
        beat_t b;
        b.dat  = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic wait_done(input string name, input int budget);
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while ((done_cnt == c0) && (n < budget)) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, 64'(done_cnt != c0), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int lat;
        int n;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        go = 1'b0; stop = 1'b0; continuous = 1'b0; swap_req = 1'b0;
        niter = '0; block_size = '0; rollover_addr = '0; tready = 1'b1;
        repeat (3) tick();

        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bank", 64'(active_bank), 64'd0);
        chk("rst_addrb", 64'(addrb_wire), 64'd0);
        rst = 1'b0;
        tick();

        // T1: bank1 <- k, swap in IDLE, 2 blocks of 8
        for (int k = 0; k < 16; k++) host_wr(k, TW'(k));
        pulse_swap();
        chk("t1_idle_swap_bank", 64'(active_bank), 64'd1);
        for (int k = 0; k < 16; k++) push(TW'(k), (k % 8) == 7);
        d0 = done_cnt;
        start(8, 2, 2047, 1'b0);
        chk("t1_busy_after_go", 64'(busy), 64'd1);
        lat = 1;
        while (!tvalid && lat < 30) begin
            tick();
            lat++;
        end
        chk("t1_first_beat_latency", 64'(lat), 64'(LAT + 2));
        wait_done("t1", 200);
        repeat (4) tick();
        chk("t1_single_done", 64'(done_cnt - d0), 64'd1);
        chk("t1_all_beats", 64'(exp_q.size()), 64'd0);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // T2: rollover at 5, address continuous across blocks
        for (int k = 0; k < 12; k++) push(TW'(k % 6), (k % 4) == 3);
        start(4, 3, 5, 1'b0);
        wait_done("t2", 200);
        repeat (2) tick();
        chk("t2_all_beats", 64'(exp_q.size()), 64'd0);

        // T3: continuous with 30% tready, stop at cycle 100
        for (int k = 0; k < 320; k++) push(TW'(k % 16), (k % 16) == 15);
        popped = 0;
        d0 = done_cnt;
        start(16, 0, 15, 1'b1);
        for (int cyc = 0; (cyc < 3000) && (done_cnt == d0); cyc++) begin
            tready = ($urandom_range(0, 99) < 30);
            stop   = (cyc == 100);
            tick();
        end
        stop   = 1'b0;
        tready = 1'b1;
        chk("t3_done_seen", 64'(done_cnt != d0), 64'd1);
        chk("t3_whole_blocks", 64'(popped % 16), 64'd0);
        chk("t3_some_blocks", 64'(popped >= 16), 64'd1);
        exp_q.delete();
        repeat (2) tick();

        // T4: bank0 <- A0+k, mid-block swap to bank1, host write during run
        for (int k = 0; k < 16; k++) host_wr(k, TW'(8'hA0 + k));
        pulse_swap();
        chk("t4_bank0_active", 64'(active_bank), 64'd0);
        for (int k = 0; k < 8; k++)  push(TW'(8'hA0 + k), k == 7);
        for (int k = 8; k < 16; k++) push(TW'(k), k == 15);
        start(8, 2, 2047, 1'b0);
        repeat (2) tick();
        pulse_swap();
        chk("t4_no_early_swap", 64'(active_bank), 64'd0);
        n = 0;
        while (!active_bank && n < 30) begin
            tick();
            n++;
        end
        chk("t4_swap_at_boundary", 64'(active_bank), 64'd1);
        host_wr(0, TW'(8'h55));
        wait_done("t4", 200);
        repeat (2) tick();
        chk("t4_all_beats", 64'(exp_q.size()), 64'd0);
        pulse_swap();
        push(TW'(8'h55), 1'b1);
        start(1, 1, 2047, 1'b0);
        wait_done("t4_readback", 100);
        repeat (2) tick();
        chk("t4_write_landed_inactive", 64'(exp_q.size()), 64'd0);

        // T5: reset during a stalled beat, then restart from address 0
        tready = 1'b0;
        start(8, 1, 2047, 1'b0);
        n = 0;
        while (!tvalid && n < 30) begin
            tick();
            n++;
        end
        chk("t5_beat_stalled", 64'(tvalid), 64'd1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("t5_tvalid_after_rst", 64'(tvalid), 64'd0);
        chk("t5_busy_after_rst", 64'(busy), 64'd0);
        chk("t5_addrb_after_rst", 64'(addrb_wire), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        tready = 1'b1;
        tick();
        push(TW'(8'h55), 1'b0);
        push(TW'(8'hA1), 1'b0);
        push(TW'(8'hA2), 1'b0);
        push(TW'(8'hA3), 1'b1);
        start(4, 1, 2047, 1'b0);
        chk("t5_restart_addr", 64'(addrb_wire), 64'd0);
        wait_done("t5", 100);
        repeat (2) tick();
        chk("t5_all_beats", 64'(exp_q.size()), 64'd0);

        // T6: zero-length runs, then go while busy
        start(0, 5, 2047, 1'b0);
        chk("t6_bs0_done", 64'(done), 64'd1);
        chk("t6_bs0_busy", 64'(busy), 64'd0);
        tick();
        chk("t6_done_one_cycle", 64'(done), 64'd0);
        chk("t6_bs0_no_tvalid", 64'(tvalid), 64'd0);
        start(4, 0, 2047, 1'b0);
        chk("t6_niter0_done", 64'(done), 64'd1);
        tick();
        tready = 1'b0;
        push(TW'(8'h55), 1'b0);
        push(TW'(8'hA1), 1'b0);
        push(TW'(8'hA2), 1'b0);
        push(TW'(8'hA3), 1'b1);
        d0 = done_cnt;
        start(4, 1, 2047, 1'b0);
        tick();
        start(2, 3, 2047, 1'b0);
        repeat (10) tick();
        tready = 1'b1;
        wait_done("t6_busy_go", 100);
        repeat (6) tick();
        chk("t6_busy_go_single_done", 64'(done_cnt - d0), 64'd1);
        chk("t6_busy_go_ignored", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
